// File: rtl/commit_trace_queue_if.sv
// Retire-trace bus: writeback retire strobe in, cosim head entry out.
// Latency: not applicable, this is wiring only.
// Backpressure: none on the retire side; out_ready throttles the consumer side.
interface commit_trace_if #(
    parameter int XLEN = 64
);
    // Retire side, driven by pipeline writeback.
    logic            in_valid;
    logic [7:0]      in_hartid;
    logic [XLEN-1:0] in_pc;
    logic [31:0]     in_inst;
    logic [XLEN-1:0] in_wdata;
    logic            in_int_xcpt;
    logic [XLEN-1:0] in_cause;

    // Consumer side, head entry presented to the cosim checker.
    logic            out_valid;
    logic            out_ready;
    logic [7:0]      out_hartid;
    logic [XLEN-1:0] out_pc;
    logic [31:0]     out_inst;
    logic [XLEN-1:0] out_wdata;
    logic            out_int_xcpt;
    logic [XLEN-1:0] out_cause;
    logic [31:0]     out_seq;

    // Producer/consumer environment around the queue.
    modport master (
        output in_valid, in_hartid, in_pc, in_inst, in_wdata, in_int_xcpt, in_cause,
        output out_ready,
        input  out_valid, out_hartid, out_pc, out_inst, out_wdata, out_int_xcpt,
        input  out_cause, out_seq
    );

    // The queue itself.
    modport slave (
        input  in_valid, in_hartid, in_pc, in_inst, in_wdata, in_int_xcpt, in_cause,
        input  out_ready,
        output out_valid, out_hartid, out_pc, out_inst, out_wdata, out_int_xcpt,
        output out_cause, out_seq
    );
endinterface

// File: rtl/commit_trace_queue.sv
// Commit trace queue: FWFT FIFO of retired instructions tagged with a sequence number.
// Latency: one cycle from retire edge to out_valid (no bypass path).
// Backpressure: retires cannot be stalled; a retire into a full queue without a pop is dropped and counted.
module commit_trace_queue #(
    parameter int DEPTH = 8,
    parameter int XLEN  = 64
) (
    input  logic                     clock,
    input  logic                     reset,
    commit_trace_if.slave            tq,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    output logic [15:0]              drop_count,
    input  logic                     clear_overflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;
    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

    // One queued retire, including the sequence number assigned at retire time.
    typedef struct packed {
        logic [7:0]      hartid;
        logic [XLEN-1:0] pc;
        logic [31:0]     inst;
        logic [XLEN-1:0] wdata;
        logic            int_xcpt;
        logic [XLEN-1:0] cause;
        logic [31:0]     seq;
    } entry_t;

    entry_t          mem_q [DEPTH];
    entry_t          wr_entry;
    entry_t          head_entry;

    logic [PW-1:0]   head_q, head_d;
    logic [PW-1:0]   tail_q, tail_d;
    logic [LW-1:0]   level_q, level_d;
    logic [31:0]     seq_q, seq_d;
    logic            ovf_q, ovf_d;
    logic [15:0]     dcnt_q, dcnt_d;

    logic            empty;
    logic            full;
    logic            pop;
    logic            push;
    logic            drop;

    // Handshake decode: a pop on a full queue frees the slot the same-edge push takes.
    always_comb begin
        empty = (level_q == '0);
        full  = (level_q == FULL_LVL);
        pop   = !empty && tq.out_ready;
        push  = tq.in_valid && (!full || pop);
        drop  = tq.in_valid && full && !pop;
    end

    // Assemble the tail entry from the retire bus and the current sequence number.
    always_comb begin
        wr_entry          = '0;
        wr_entry.hartid   = tq.in_hartid;
        wr_entry.pc       = tq.in_pc;
        wr_entry.inst     = tq.in_inst;
        wr_entry.wdata    = tq.in_wdata;
        wr_entry.int_xcpt = tq.in_int_xcpt;
        wr_entry.cause    = tq.in_cause;
        wr_entry.seq      = seq_q;
    end

    // Next-state for pointers, occupancy, sequence counter and drop bookkeeping.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        level_d = level_q;
        seq_d   = seq_q;
        ovf_d   = ovf_q;
        dcnt_d  = dcnt_q;

        // Pointers are exactly PW bits wide, so the increment wraps modulo DEPTH.
        if (pop) begin
            head_d = head_q + PW'(1);
        end
        if (push) begin
            tail_d = tail_q + PW'(1);
        end

        case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase

        // Every retire consumes a number, dropped or not, so drops show as seq gaps.
        if (tq.in_valid) begin
            seq_d = seq_q + 32'd1;
        end

        // A drop on the same edge as a clear restarts the count at one.
        if (drop) begin
            ovf_d = 1'b1;
            if (clear_overflow) begin
                dcnt_d = 16'd1;
            end else if (dcnt_q != 16'hFFFF) begin
                dcnt_d = dcnt_q + 16'd1;
            end
        end else if (clear_overflow) begin
            ovf_d  = 1'b0;
            dcnt_d = 16'd0;
        end
    end

    // Control state; reset discards all queued entries and restarts numbering at zero.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            level_q <= '0;
            seq_q   <= '0;
            ovf_q   <= 1'b0;
            dcnt_q  <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            level_q <= level_d;
            seq_q   <= seq_d;
            ovf_q   <= ovf_d;
            dcnt_q  <= dcnt_d;
        end
    end

    // Entry storage is not reset; stale contents are hidden by the out_valid mask below.
    always_ff @(posedge clock) begin
        if (push && reset) begin
            mem_q[tail_q] <= wr_entry;
        end
    end

    // Head entry fall-through, forced to zero whenever nothing valid is at the head.
    always_comb begin
        head_entry = empty ? '0 : mem_q[head_q];
    end

    assign tq.out_valid    = !empty;
    assign tq.out_hartid   = head_entry.hartid;
    assign tq.out_pc       = head_entry.pc;
    assign tq.out_inst     = head_entry.inst;
    assign tq.out_wdata    = head_entry.wdata;
    assign tq.out_int_xcpt = head_entry.int_xcpt;
    assign tq.out_cause    = head_entry.cause;
    assign tq.out_seq      = head_entry.seq;

    assign level      = level_q;
    assign overflow   = ovf_q;
    assign drop_count = dcnt_q;

endmodule

// File: tb/tb_commit_trace_queue.sv
// Scoreboard bench for commit_trace_queue: reference queue model checked every cycle.
// Latency: expects head entry visible one edge after its retire.
// Backpressure: exercises full/drop, full push+pop, clear race, saturation and mid-op reset.
module tb_commit_trace_queue;

    localparam int DEPTH = 8;
    localparam int XLEN  = 64;

    typedef struct {
        logic [7:0]  hartid;
        logic [63:0] pc;
        logic [31:0] inst;
        logic [63:0] wdata;
        logic        xcpt;
        logic [63:0] cause;
        logic [31:0] seq;
    } exp_t;

    logic        clock;
    logic        reset;
    logic [3:0]  level;
    logic        overflow;
    logic [15:0] drop_count;
    logic        clear_overflow;

    commit_trace_if #(.XLEN(XLEN)) tq ();

    commit_trace_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .clock          (clock),
        .reset          (reset),
        .tq             (tq.slave),
        .level          (level),
        .overflow       (overflow),
        .drop_count     (drop_count),
        .clear_overflow (clear_overflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    exp_t        mq[$];
    logic [31:0] m_seq;
    logic        m_ovf;
    logic [15:0] m_dcnt;
    int          n_chk;
    int          n_pass;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_seq  = '0;
        m_ovf  = 1'b0;
        m_dcnt = '0;
    endtask

    task automatic drive(input logic v, input logic rdy, input logic clr);
        tq.in_valid    = v;
        tq.out_ready   = rdy;
        clear_overflow = clr;
        tq.in_hartid   = 8'($urandom);
        tq.in_pc       = {$urandom, $urandom};
        tq.in_inst     = $urandom;
        tq.in_wdata    = {$urandom, $urandom};
        tq.in_int_xcpt = 1'($urandom);
        tq.in_cause    = {$urandom, $urandom};
    endtask

    // One clock: compare head on consumer pop, advance model at the edge, check status after.
    task automatic tick();
        logic do_pop, do_push, do_drop;
        exp_t e, h;
        do_pop = (mq.size() != 0) && tq.out_ready;
        if (do_pop && tq.out_valid) begin
            h = mq[0];
            chk("head_seq",   64'(tq.out_seq),   64'(h.seq));
            chk("head_pc",    tq.out_pc,         h.pc);
            chk("head_wdata", tq.out_wdata,      h.wdata);
            chk("head_cause", tq.out_cause,      h.cause);
            chk("head_misc",  64'({tq.out_hartid, tq.out_inst, tq.out_int_xcpt}),
                              64'({h.hartid, h.inst, h.xcpt}));
        end
        @(posedge clock);
        do_push = tq.in_valid && ((mq.size() < DEPTH) || do_pop);
        do_drop = tq.in_valid && !do_push;
        e.hartid = tq.in_hartid;
        e.pc     = tq.in_pc;
        e.inst   = tq.in_inst;
        e.wdata  = tq.in_wdata;
        e.xcpt   = tq.in_int_xcpt;
        e.cause  = tq.in_cause;
        e.seq    = m_seq;
        if (do_pop)  void'(mq.pop_front());
        if (do_push) mq.push_back(e);
        if (tq.in_valid) m_seq = m_seq + 32'd1;
        if (do_drop) begin
            m_ovf  = 1'b1;
            m_dcnt = clear_overflow ? 16'd1 : ((m_dcnt == 16'hFFFF) ? m_dcnt : m_dcnt + 16'd1);
        end else if (clear_overflow) begin
            m_ovf  = 1'b0;
            m_dcnt = 16'd0;
        end
        #1;
        chk("level",      64'(level),        64'(mq.size()));
        chk("out_valid",  64'(tq.out_valid), 64'(mq.size() != 0));
        chk("overflow",   64'(overflow),     64'(m_ovf));
        chk("drop_count", 64'(drop_count),   64'(m_dcnt));
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        #1;
        model_reset();
        chk("rst_valid", 64'(tq.out_valid), 64'd0);
        chk("rst_level", 64'(level),        64'd0);
        chk("rst_ovf",   64'(overflow),     64'd0);
        chk("rst_dcnt",  64'(drop_count),   64'd0);
        chk("rst_pc",    tq.out_pc,         64'd0);
        chk("rst_seq",   64'(tq.out_seq),   64'd0);
        @(negedge clock);
        reset = 1'b1;
    endtask

    initial begin
        n_chk  = 0;
        n_pass = 0;
        model_reset();
        drive(1'b1, 1'b1, 1'b0);   // ignored while in reset
        apply_reset();
        drive(1'b0, 1'b0, 1'b0);

        // Single retire, then pop.
        drive(1'b1, 1'b0, 1'b0);
        tq.in_pc   = 64'h8000_0000;
        tq.in_inst = 32'h0000_0013;
        tick();
        chk("single_pc",  tq.out_pc,         64'h8000_0000);
        chk("single_seq", 64'(tq.out_seq),   64'd0);
        chk("single_lvl", 64'(level),        64'd1);
        drive(1'b0, 1'b1, 1'b0);
        tick();
        chk("single_pop_lvl", 64'(level),        64'd0);
        chk("single_pop_vld", 64'(tq.out_valid), 64'd0);

        // Empty with out_ready: nothing moves.
        drive(1'b0, 1'b1, 1'b0);
        tick();
        chk("empty_rdy_lvl", 64'(level), 64'd0);

        // Fill and overflow from a clean reset: 10 retires into 8 slots.
        apply_reset();
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 1'b0, 1'b0);
            tick();
        end
        chk("fill_lvl",  64'(level),      64'd8);
        chk("fill_ovf",  64'(overflow),   64'd1);
        chk("fill_dcnt", 64'(drop_count), 64'd2);
        for (int i = 0; i < 8; i++) begin
            chk("drain_seq", 64'(tq.out_seq), 64'(i));
            drive(1'b0, 1'b1, 1'b0);
            tick();
        end
        drive(1'b1, 1'b0, 1'b0);
        tick();
        chk("post_drop_seq", 64'(tq.out_seq), 64'd10);

        // Full with simultaneous push and pop for 20 cycles.
        drive(1'b0, 1'b0, 1'b1);
        tick();
        for (int i = 0; i < 7; i++) begin
            drive(1'b1, 1'b0, 1'b0);
            tick();
        end
        chk("pp_full_lvl", 64'(level), 64'd8);
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 1'b1, 1'b0);
            tick();
            chk("pp_lvl", 64'(level),    64'd8);
            chk("pp_ovf", 64'(overflow), 64'd0);
        end

        // Clear racing a drop while drop_count is 5.
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b0, 1'b0);
            tick();
        end
        chk("race_pre_dcnt", 64'(drop_count), 64'd5);
        drive(1'b1, 1'b0, 1'b1);
        tick();
        chk("race_ovf",  64'(overflow),   64'd1);
        chk("race_dcnt", 64'(drop_count), 64'd1);
        drive(1'b0, 1'b0, 1'b1);
        tick();
        chk("clr_ovf",  64'(overflow),   64'd0);
        chk("clr_dcnt", 64'(drop_count), 64'd0);

        // Saturating drop counter.
        for (int i = 0; i < 65540; i++) begin
            drive(1'b1, 1'b0, 1'b0);
            tick();
        end
        chk("sat_dcnt", 64'(drop_count), 64'hFFFF);

        // Random retire/consume traffic against the model.
        for (int i = 0; i < 5000; i++) begin
            drive(1'($urandom_range(0, 9) < 6), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 49) == 0));
            tick();
        end

        // Reset asserted between edges with five entries queued.
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b0, 1'b0);
            tick();
        end
        chk("mid_pre_lvl", 64'(level), 64'd5);
        reset = 1'b0;
        #1;
        chk("mid_rst_vld", 64'(tq.out_valid), 64'd0);
        chk("mid_rst_lvl", 64'(level),        64'd0);
        model_reset();
        @(negedge clock);
        reset = 1'b1;
        drive(1'b1, 1'b0, 1'b0);
        tick();
        chk("mid_post_seq", 64'(tq.out_seq), 64'd0);

        // Drain and confirm nothing is left over.
        for (int i = 0; i < DEPTH + 2; i++) begin
            drive(1'b0, 1'b1, 1'b0);
            tick();
        end
        chk("final_empty", 64'(tq.out_valid), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
